// File: rtl/shift_8x64_tap_reader_if.sv
// Bus bundle for the 8x64 tap reader: shift port, burst request channel, response channel, status.
interface shift_8x64_tap_reader_if;
  logic       shift;
  logic       shift_ready;
  logic [7:0] sr_in;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] tap_sel;
  logic [2:0] req_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_last;
  logic [6:0] fill;
  logic       overrun;

  modport master (
    output shift, sr_in, req_valid, tap_sel, req_len, rsp_ready,
    input  shift_ready, req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, fill, overrun
  );

  modport slave (
    input  shift, sr_in, req_valid, tap_sel, req_len, rsp_ready,
    output shift_ready, req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, fill, overrun
  );
endinterface

// File: rtl/shift_8x64_tap_reader.sv
// 64-deep, 8-bit circular shift register with a burst tap reader.
// Tap 0 is the newest sample; shifts arriving during a burst are dropped and flagged as overrun.
module shift_8x64_tap_reader (
  input logic                     clk,
  input logic                     rst,
  shift_8x64_tap_reader_if.slave  bus
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t     state_q;
  logic [7:0] mem_q [64];
  logic [5:0] wp_q, baseWp_q, tap_q;
  logic [6:0] fill_q, baseFill_q;
  logic [2:0] len_q, beat_q;
  logic       overrun_q, rspErr_q, rspLast_q;
  logic [7:0] rspData_q;

  logic       shiftAcc, reqAcc;
  logic [5:0] lkWp, lkAddr;
  logic [6:0] lkFill, lkTap;
  logic [2:0] lkBeat, lkLen;
  logic       lkErr, lkLast;
  logic [7:0] lkData;

  assign shiftAcc = bus.shift && (state_q == IDLE);
  assign reqAcc   = bus.req_valid && (state_q == IDLE) && !bus.shift;

  assign bus.shift_ready = (state_q == IDLE);
  assign bus.req_ready   = (state_q == IDLE) && !bus.shift;
  assign bus.rsp_valid   = (state_q == BURST);
  assign bus.rsp_data    = rspData_q;
  assign bus.rsp_err     = rspErr_q;
  assign bus.rsp_last    = rspLast_q;
  assign bus.fill        = fill_q;
  assign bus.overrun     = overrun_q;

  // Resolves the beat to be registered at the next edge: beat 0 of a new request
  // while idle, otherwise the following beat of the latched burst.
  always_comb begin
    lkWp   = wp_q;
    lkFill = fill_q;
    lkBeat = 3'd0;
    lkLen  = bus.req_len;
    lkTap  = {1'b0, bus.tap_sel};
    if (state_q == BURST) begin
      lkWp   = baseWp_q;
      lkFill = baseFill_q;
      lkBeat = beat_q + 3'd1;
      lkLen  = len_q;
      lkTap  = {1'b0, tap_q} + {4'b0000, lkBeat};
    end
    lkAddr = lkWp - 6'd1 - lkTap[5:0];
    lkErr  = lkTap[6] || (lkTap >= lkFill);
    lkData = lkErr ? 8'h00 : mem_q[lkAddr];
    lkLast = (lkBeat == lkLen);
  end

  // Sample storage carries no reset; fill=0 marks every tap invalid instead.
  always_ff @(posedge clk) begin
    if (shiftAcc) mem_q[wp_q] <= bus.sr_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wp_q       <= 6'd0;
      fill_q     <= 7'd0;
      overrun_q  <= 1'b0;
      baseWp_q   <= 6'd0;
      baseFill_q <= 7'd0;
      tap_q      <= 6'd0;
      len_q      <= 3'd0;
      beat_q     <= 3'd0;
      rspData_q  <= 8'h00;
      rspErr_q   <= 1'b0;
      rspLast_q  <= 1'b0;
    end else begin
      if (shiftAcc) begin
        wp_q <= wp_q + 6'd1;
        if (fill_q != 7'd64) fill_q <= fill_q + 7'd1;
      end
      if (bus.shift && (state_q != IDLE)) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (reqAcc) begin
            state_q    <= BURST;
            baseWp_q   <= wp_q;
            baseFill_q <= fill_q;
            tap_q      <= bus.tap_sel;
            len_q      <= bus.req_len;
            beat_q     <= 3'd0;
            rspData_q  <= lkData;
            rspErr_q   <= lkErr;
            rspLast_q  <= lkLast;
          end
        end
        BURST: begin
          if (bus.rsp_ready) begin
            if (rspLast_q) begin
              state_q   <= IDLE;
              rspLast_q <= 1'b0;
            end else begin
              beat_q    <= lkBeat;
              rspData_q <= lkData;
              rspErr_q  <= lkErr;
              rspLast_q <= lkLast;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_8x64_tap_reader.sv
// Directed bench for shift_8x64_tap_reader: fill, partial fill, saturation, stall, collision, reset and back-to-back bursts.
module tb_shift_8x64_tap_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  shift_8x64_tap_reader_if bus ();

  shift_8x64_tap_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_shift(input logic [7:0] v);
    bus.shift = 1'b1;
    bus.sr_in = v;
    tick();
    bus.shift = 1'b0;
  endtask

  task automatic start_req(input logic [5:0] tap, input logic [2:0] len);
    bus.req_valid = 1'b1;
    bus.tap_sel   = tap;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.fill !== 7'd0) begin errors++; $display("[TB] FAIL reset_fill: got %0d expected 0", bus.fill); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
    checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_last} !== 10'd0) begin errors++; $display("[TB] FAIL reset_rsp: got %h/%b/%b expected 00/0/0", bus.rsp_data, bus.rsp_err, bus.rsp_last); end
    checks++; if ({bus.shift_ready, bus.req_ready} !== 2'b11) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 11", {bus.shift_ready, bus.req_ready}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] expD [3];
    expD[0] = 8'h05; expD[1] = 8'h04; expD[2] = 8'h03;
    for (int i = 1; i <= 5; i++) do_shift(8'(i));
    checks++; if (bus.fill !== 7'd5) begin errors++; $display("[TB] FAIL basic_fill: got %0d expected 5", bus.fill); end
    start_req(6'd0, 3'd2);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {1'b1, expD[i], 1'b0, (i == 2)}) begin
        errors++; $display("[TB] FAIL basic_beat%0d: got v=%b d=%h e=%b l=%b expected v=1 d=%h e=0 l=%b", i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_last, expD[i], (i == 2));
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_end: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_partial();
    start_req(6'd4, 3'd1);
    checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {8'h01, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL partial_beat0: got d=%h e=%b l=%b expected d=01 e=0 l=0", bus.rsp_data, bus.rsp_err, bus.rsp_last); end
    bus.rsp_ready = 1'b1;
    tick();
    checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL partial_beat1: got d=%h e=%b l=%b expected d=00 e=1 l=1", bus.rsp_data, bus.rsp_err, bus.rsp_last); end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] expD [4];
    logic       expE [4];
    expD[0] = 8'h07; expD[1] = 8'h06; expD[2] = 8'h00; expD[3] = 8'h00;
    expE[0] = 1'b0;  expE[1] = 1'b0;  expE[2] = 1'b1;  expE[3] = 1'b1;
    do_reset();
    for (int i = 0; i < 70; i++) do_shift(8'(i));
    checks++; if (bus.fill !== 7'd64) begin errors++; $display("[TB] FAIL sat_fill: got %0d expected 64", bus.fill); end
    start_req(6'd63, 3'd0);
    checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {8'h06, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL sat_tap63: got d=%h e=%b l=%b expected d=06 e=0 l=1", bus.rsp_data, bus.rsp_err, bus.rsp_last); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    start_req(6'd62, 3'd3);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {expD[i], expE[i], (i == 3)}) begin
        errors++; $display("[TB] FAIL sat_beat%0d: got d=%h e=%b l=%b expected d=%h e=%b l=%b", i, bus.rsp_data, bus.rsp_err, bus.rsp_last, expD[i], expE[i], (i == 3));
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 5; i++) do_shift(8'(i));
    start_req(6'd0, 3'd2);
    bus.shift = 1'b1;
    bus.sr_in = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.shift_ready} !== {1'b1, 8'h05, 1'b0}) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got v=%b d=%h sr=%b expected v=1 d=05 sr=0", i, bus.rsp_valid, bus.rsp_data, bus.shift_ready);
      end
      tick();
    end
    bus.shift = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL stall_overrun: got %b expected 1", bus.overrun); end
    checks++; if (bus.fill !== 7'd5) begin errors++; $display("[TB] FAIL stall_fill: got %0d expected 5", bus.fill); end
    bus.rsp_ready = 1'b1;
    tick();
    checks++; if (bus.rsp_data !== 8'h04) begin errors++; $display("[TB] FAIL stall_beat1: got %h expected 04", bus.rsp_data); end
    tick();
    tick();
    bus.rsp_ready = 1'b0;
    start_req(6'd0, 3'd0);
    checks++; if (bus.rsp_data !== 8'h05) begin errors++; $display("[TB] FAIL stall_nowrite: got %h expected 05", bus.rsp_data); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_collision();
    bus.shift     = 1'b1;
    bus.sr_in     = 8'h77;
    bus.req_valid = 1'b1;
    bus.tap_sel   = 6'd0;
    bus.req_len   = 3'd0;
    #1;
    checks++; if ({bus.req_ready, bus.shift_ready} !== 2'b01) begin errors++; $display("[TB] FAIL coll_ready: got rr=%b sr=%b expected rr=0 sr=1", bus.req_ready, bus.shift_ready); end
    tick();
    bus.shift = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.req_ready, bus.fill} !== {1'b0, 1'b1, 7'd6}) begin errors++; $display("[TB] FAIL coll_retry: got v=%b rr=%b fill=%0d expected v=0 rr=1 fill=6", bus.rsp_valid, bus.req_ready, bus.fill); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {1'b1, 8'h77, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL coll_beat: got v=%b d=%h e=%b l=%b expected v=1 d=77 e=0 l=1", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_last); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_req(6'd0, 3'd3);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_data !== 8'h05) begin errors++; $display("[TB] FAIL rmid_beat1: got %h expected 05", bus.rsp_data); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.rsp_valid, bus.fill, bus.overrun, bus.rsp_data} !== {1'b0, 7'd0, 1'b0, 8'h00}) begin errors++; $display("[TB] FAIL rmid_abort: got v=%b fill=%0d ovr=%b d=%h expected v=0 fill=0 ovr=0 d=00", bus.rsp_valid, bus.fill, bus.overrun, bus.rsp_data); end
    rst = 1'b0;
    tick();
    start_req(6'd0, 3'd0);
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_last} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL rmid_after: got v=%b d=%h e=%b l=%b expected v=1 d=00 e=1 l=1", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_last); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1;
    bus.tap_sel   = 6'd0;
    bus.req_len   = 3'd0;
    tick();
    bus.rsp_ready = 1'b1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got %b expected 1", bus.rsp_valid); end
    tick();
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_gap: got v=%b rr=%b expected v=0 rr=1", bus.rsp_valid, bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_second: got v=%b e=%b expected v=1 e=1", bus.rsp_valid, bus.rsp_err); end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.shift     = 1'b0;
    bus.sr_in     = 8'h00;
    bus.req_valid = 1'b0;
    bus.tap_sel   = 6'd0;
    bus.req_len   = 3'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_saturate();
    test_stall();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
